// File: rtl/camera_param_latch.sv
`default_nettype none
// ============================================================================
// Module   : camera_param_latch
// Brief    : Debounces the 12 HPS camera words and commits a coherent
//            snapshot to the raymarcher only on frame_start. Optional
//            commit/drop statistics are enabled with CAM_UPDATE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module camera_param_latch #(
    parameter int                DATA_W        = 32,
    parameter int                STABLE_CYCLES = 16,
    parameter int                CNT_W         = 5,
    parameter logic [DATA_W-1:0] FIX_ONE       = DATA_W'(32'h0001_0000)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3*DATA_W-1:0] eye_in,
    input  logic [9*DATA_W-1:0] lookat_in,
    input  logic                frame_start,
    output logic [3*DATA_W-1:0] eye_out,
    output logic [9*DATA_W-1:0] lookat_out,
    output logic                params_valid,
    output logic                param_update,
`ifdef CAM_UPDATE_STATS_EN
    output logic [15:0]         commit_count,
    output logic [15:0]         drop_count,
`endif
    output logic                pending
);

    localparam int               EYE_W     = 3 * DATA_W;
    localparam int               ALL_W     = 12 * DATA_W;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_PENDING = 2'd2;

    logic [ALL_W-1:0]    w_in;
    logic                w_change;
    logic [9*DATA_W-1:0] w_identity;
    logic [ALL_W-1:0]    r_snap;
    logic [ALL_W-1:0]    r_shadow;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic                w_capture;
    logic                w_commit;

    assign w_in     = {lookat_in, eye_in};
    assign w_change = (w_in != r_snap);
    assign pending  = (r_state == S_PENDING);

    // Row-major 3x3: diagonal elements sit at word indices 0, 4 and 8.
    for (genvar g = 0; g < 9; g++) begin : g_identity
        assign w_identity[g*DATA_W +: DATA_W] = (g % 4 == 0) ? FIX_ONE : '0;
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_change) w_state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (!w_change && (r_cnt == C_CNT_MAX)) begin
                    w_capture    = 1'b1;
                    w_state_next = S_PENDING;
                end
            end
            S_PENDING: begin
                // A stable shadow is committed even if the inputs move this cycle.
                if (frame_start) begin
                    w_commit     = 1'b1;
                    w_state_next = w_change ? S_SETTLE : S_IDLE;
                end else if (w_change) begin
                    w_state_next = S_SETTLE;
                end
            end
            default: w_state_next = S_SETTLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap       <= '0;
            r_shadow     <= '0;
            r_cnt        <= '0;
            r_state      <= S_SETTLE;
            eye_out      <= '0;
            lookat_out   <= w_identity;
            params_valid <= 1'b0;
            param_update <= 1'b0;
        end else begin
            r_snap       <= w_in;
            r_state      <= w_state_next;
            param_update <= w_commit;
            if (w_change)
                r_cnt <= '0;
            else if (r_cnt < C_CNT_MAX)
                r_cnt <= r_cnt + 1'b1;
            if (w_capture)
                r_shadow <= w_in;
            if (w_commit) begin
                eye_out      <= r_shadow[EYE_W-1:0];
                lookat_out   <= r_shadow[ALL_W-1:EYE_W];
                params_valid <= 1'b1;
            end
        end
    end

`ifdef CAM_UPDATE_STATS_EN
    logic w_drop;
    assign w_drop = (r_state == S_PENDING) && !frame_start && w_change;

    always_ff @(posedge clk) begin
        if (reset) begin
            commit_count <= '0;
            drop_count   <= '0;
        end else begin
            if (w_commit) commit_count <= commit_count + 16'd1;
            if (w_drop)   drop_count   <= drop_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_camera_param_latch.sv
`default_nettype none
// ============================================================================
// Module   : tb_camera_param_latch
// Brief    : Directed and random stimulus against a behavioural camera model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_camera_param_latch;

    localparam int DW     = 32;
    localparam int STABLE = 16;

    logic           clk;
    logic           reset;
    logic [383:0]   r_tb_in;
    logic [95:0]    w_eye_in;
    logic [287:0]   w_lookat_in;
    logic           frame_start;
    logic [95:0]    eye_out;
    logic [287:0]   lookat_out;
    logic           params_valid;
    logic           param_update;
    logic           pending;
`ifdef CAM_UPDATE_STATS_EN
    logic [15:0]    commit_count;
    logic [15:0]    drop_count;
`endif

    assign w_eye_in    = r_tb_in[95:0];
    assign w_lookat_in = r_tb_in[383:96];

    camera_param_latch #(
        .DATA_W(DW), .STABLE_CYCLES(STABLE), .CNT_W(5), .FIX_ONE(32'h0001_0000)
    ) u_dut (
        .clk(clk), .reset(reset), .eye_in(w_eye_in), .lookat_in(w_lookat_in),
        .frame_start(frame_start), .eye_out(eye_out), .lookat_out(lookat_out),
        .params_valid(params_valid), .param_update(param_update),
`ifdef CAM_UPDATE_STATS_EN
        .commit_count(commit_count), .drop_count(drop_count),
`endif
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: tracks how long the inputs have been unchanged,
    // whether a snapshot is held, and whether the last commit is still current.
    logic [383:0] m_prev;
    int           m_run;
    bit           m_holding;
    bit           m_in_sync;
    logic [383:0] m_held;
    logic [95:0]  m_eye;
    logic [287:0] m_look;
    bit           m_valid;
    bit           m_upd;
    int           m_commits;
    int           m_drops;

    function automatic logic [287:0] identity();
        logic [287:0] v;
        v = '0;
        v[0*DW +: DW] = 32'h0001_0000;
        v[4*DW +: DW] = 32'h0001_0000;
        v[8*DW +: DW] = 32'h0001_0000;
        return v;
    endfunction

    task automatic model_reset();
        m_prev = '0; m_run = 0; m_holding = 0; m_in_sync = 0; m_held = '0;
        m_eye = '0; m_look = identity(); m_valid = 0; m_upd = 0;
        m_commits = 0; m_drops = 0;
    endtask

    task automatic model_edge(input logic [383:0] cur, input bit fs);
        bit moved;
        moved = (cur != m_prev);
        m_run = moved ? 0 : m_run + 1;
        m_upd = 0;
        if (m_holding) begin
            if (fs) begin
                m_eye = m_held[95:0]; m_look = m_held[383:96];
                m_valid = 1; m_upd = 1; m_commits++;
                m_holding = 0; m_in_sync = !moved;
            end else if (moved) begin
                m_holding = 0; m_drops++;
            end
        end else if (m_in_sync) begin
            if (moved) m_in_sync = 0;
        end else if (m_run >= STABLE) begin
            m_held = cur; m_holding = 1;
        end
        m_prev = cur;
    endtask

    task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("pending", 288'(pending), 288'(m_holding));
        check("eye_out", 288'(eye_out), 288'(m_eye));
        check("lookat_out", lookat_out, m_look);
        check("params_valid", 288'(params_valid), 288'(m_valid));
        check("param_update", 288'(param_update), 288'(m_upd));
`ifdef CAM_UPDATE_STATS_EN
        check("commit_count", 288'(commit_count), 288'(m_commits[15:0]));
        check("drop_count", 288'(drop_count), 288'(m_drops[15:0]));
`endif
    endtask

    task automatic tick(input bit fs);
        frame_start = fs;
        @(posedge clk);
        model_edge(r_tb_in, fs);
        @(negedge clk);
        frame_start = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_all();
    endtask

    task automatic wait_pending(input int limit);
        int n;
        n = 0;
        while (!m_holding && n < limit) begin
            tick(1'b0);
            n++;
        end
        check("wait_pending_timeout", 288'(pending), 288'(1));
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        r_tb_in[idx*DW +: DW] = val;
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; r_tb_in = '0;
        @(negedge clk);
        do_reset();
        check("reset_identity", lookat_out, identity());
        check("reset_eye", 288'(eye_out), 288'(0));

        // Constant camera: eye {3,2,1}, every lookat word 5.
        set_word(0, 32'd1); set_word(1, 32'd2); set_word(2, 32'd3);
        for (int i = 3; i < 12; i++) set_word(i, 32'd5);
        for (int i = 0; i < 16; i++) tick(1'b0);
        check("pending_before_16", 288'(pending), 288'(0));
        tick(1'b0);
        check("pending_after_16", 288'(pending), 288'(1));
        tick(1'b1);
        check("eye_321", 288'(eye_out), 288'({32'd3, 32'd2, 32'd1}));
        check("pulse_high", 288'(param_update), 288'(1));
        tick(1'b0);
        check("pulse_low", 288'(param_update), 288'(0));

        // Tearing writes: no commit can ever happen.
        for (int i = 0; i < 200; i++) begin
            if (i % 10 == 0) set_word(0, $urandom);
            tick(i % 50 == 49);
        end
        check("tear_hold", 288'(eye_out), 288'({32'd3, 32'd2, 32'd1}));

        // Pending snapshot discarded by a late change.
        set_word(0, 32'd7);
        wait_pending(40);
        set_word(0, 32'd9);
        tick(1'b0);
        wait_pending(40);
        tick(1'b1);
        check("eye_x_9", 288'(eye_out[31:0]), 288'(9));

        // Commit wins over a simultaneous change, then no commit from SETTLE.
        set_word(0, 32'd4);
        wait_pending(40);
        set_word(0, 32'd5);
        tick(1'b1);
        check("eye_x_4", 288'(eye_out[31:0]), 288'(4));
        for (int i = 0; i < 3; i++) tick(1'b1);
        check("settle_no_commit", 288'(eye_out[31:0]), 288'(4));

        // Random camera writes and frame pulses.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) set_word($urandom_range(0, 11), $urandom);
            tick($urandom_range(0, 24) == 0);
        end

        // Reset while a snapshot is pending.
        set_word(5, 32'hDEAD_BEEF);
        wait_pending(40);
        do_reset();
        check("rst_pending", 288'(pending), 288'(0));
        check("rst_identity", lookat_out, identity());

        // All-zero inputs still yield a first commit.
        r_tb_in = '0;
        do_reset();
        wait_pending(40);
        tick(1'b1);
        check("zero_commit_valid", 288'(params_valid), 288'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/camera_param_latch.md
Name: camera_param_latch

Overview:
FPGA-side consumer of the HPS camera PIOs (eye_x/y/z, lookat 3x3). The HPS writes these 12 words one at a time, so the raw exports can tear mid-update. This block waits until all 12 words have been stable for a programmable settle time, holds that snapshot, and commits it to the raymarcher only on a frame boundary. The renderer therefore always sees one coherent camera for a whole frame.

Parameters:
DATA_W, 32, width of each camera word
STABLE_CYCLES, 16, consecutive no-change cycles needed before a snapshot is accepted (>=2)
CNT_W, 5, stability counter width; must hold STABLE_CYCLES
FIX_ONE, 32'h0001_0000, encoding of 1.0 used for the reset identity matrix

Ports:
clk  in  1  system clock; all logic in this domain (PIO exports are already synchronous to it)
reset  in  1  synchronous, active-high reset
eye_in  in  3*DATA_W  packed {z,y,x}, from eye_*_export
lookat_in  in  9*DATA_W  packed, lookat_1_1 at LSB through lookat_3_3 at MSB, row-major
frame_start  in  1  one-cycle pulse from VGA/render control at start of frame (vsync)
eye_out  out  3*DATA_W  committed eye, same packing
lookat_out  out  9*DATA_W  committed lookat, same packing
params_valid  out  1  high once the first commit has happened
param_update  out  1  one-cycle pulse in the cycle after a commit
pending  out  1  high while a stable snapshot waits for frame_start

Behaviour:
- Only one clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset values:
  - eye_out = 0.
  - lookat_out = identity: diagonal FIX_ONE, others 0.
  - params_valid = 0, param_update = 0, pending = 0.
  - snap = 0, shadow = 0, cnt = 0, state = SETTLE.
- Change detection:
  - snap <= {lookat_in, eye_in} every cycle.
  - change = ({lookat_in, eye_in} != snap), combinational.
- Stability counter: change -> cnt <= 0; else if cnt < STABLE_CYCLES-1 -> cnt <= cnt+1. Saturates.
- FSM states: IDLE, SETTLE, PENDING.
  - IDLE: committed values match the inputs. change -> SETTLE.
  - SETTLE:
    - !change && cnt == STABLE_CYCLES-1 -> shadow <= inputs; go to PENDING.
    - Net effect: the snapshot is taken on the STABLE_CYCLES-th consecutive no-change cycle.
    - frame_start in SETTLE is ignored; outputs hold.
  - PENDING: pending = 1.
    - frame_start -> eye_out/lookat_out <= shadow, params_valid <= 1, param_update pulses next cycle.
    - After the commit: go to IDLE, or to SETTLE if change is also high that cycle.
    - change without frame_start -> discard shadow, go to SETTLE, cnt = 0.
- Simultaneous frame_start and change in PENDING: commit wins. shadow was already stable, so it is committed and the FSM enters SETTLE.
- Commit latency: outputs update at the clock edge that samples frame_start; param_update is registered and high for exactly 1 cycle after.
- After reset the FSM starts in SETTLE, so constant inputs (including all-zero) still produce a first commit.
- Reset asserted mid-PENDING: shadow is dropped, outputs return to reset values, params_valid = 0.
- Outputs change only on a commit, never mid-frame.

Optional Feature:
CAM_UPDATE_STATS_EN
- Defined:
  - Adds output commit_count [15:0]: +1 per commit, wraps 16'hFFFF -> 0.
  - Adds output drop_count [15:0]: +1 each time a PENDING snapshot is discarded by change, wraps.
  - Both counters reset to 0.
- Undefined: neither port exists, and no counter logic is generated.

Test Plan:
- Reset, inputs held at eye = {3,2,1}, all lookat = 5, STABLE_CYCLES = 16 -> pending rises after 16 cycles. frame_start then commits eye_out = {3,2,1}; param_update pulses once; params_valid = 1.
- Immediately after reset, before any commit -> lookat_out diagonal = 32'h0001_0000, off-diagonal 0, eye_out = 0, params_valid = 0.
- Change eye_x every 10 cycles while pulsing frame_start every 50 cycles -> no commit ever; outputs stay at their previous values.
- Pending snapshot eye_x = 7, then eye_x changed to 9 before frame_start -> snapshot 7 discarded (drop_count = 1 when enabled). After 16 stable cycles and frame_start, eye_out x = 9.
- frame_start and an input change in the same cycle while PENDING with eye_x = 4 -> eye_out x = 4 is committed, state becomes SETTLE, and the next frame_start does not commit.
- With CAM_UPDATE_STATS_EN: 65537 commits -> commit_count = 1 (wrap). Reset asserted during PENDING -> outputs back to identity/0, pending = 0.
